sw_counter_ctrl: RTL
====================

// Module: sw_counter_ctrl
// PURPOSE
//   Sequential value source for the 10-bit binary-to-BCD / HEX display path.
//   - Holds a 10-bit count that the user can load from the switches, run up or down at a prescaled rate, or freeze.
//   - Sits directly upstream of the combinational double-dabble converter: count[9:0] drives its binary input.
//   - Replaces the raw SW[9:0] connection at the top level.
// PARAMETERS
//   PRESCALE   50_000_000  clk cycles per count step while running (>=1)
//   MAX_COUNT  999         highest count value, wrap/saturate bound (<=1023)
// PORTS
//   clk       in   1   system clock, single clock domain
//   rst       in   1   synchronous, active-high reset
//   load_val  in   10  value to load (switch bank, level)
//   load_n    in   1   load push-button, active-low, asynchronous to clk
//   run_n     in   1   run/stop push-button, active-low, asynchronous to clk
//   dir       in   1   count direction, level, asynchronous: 1=up, 0=down
//   count     out  10  current count, registered, feeds BCD converter
//   running   out  1   1 = RUN state, 0 = STOP state
//   tick      out  1   one-cycle pulse in the cycle after count is updated
// BEHAVIOUR
//   Reset: sampled only on rising clk edge with rst=1.
//   - count=0, state=STOP, running=0, tick=0, prescaler=0.
//   - Synchronizer and edge registers for the buttons are set to 1 (released).
//   - rst overrides every other input in that cycle.
//   Input conditioning:
//   - load_n, run_n and dir each pass through a 2-flop synchronizer.
//   - Each button has one further history flop. A press is detected when history=1 and synced=0.
//   - A press is a single-cycle event, 3 clk edges after the pin falls.
//   - A held button produces only one press; release produces no event.
//   State machine (2 states):
//   - STOP: count held, prescaler held at 0. A run press moves to RUN and clears the prescaler.
//   - RUN: the prescaler counts 0..PRESCALE-1. At PRESCALE-1 it wraps to 0 and a step occurs. A run press moves to STOP.
//   - running is the registered state bit.
//   Step, using synchronized dir sampled in the step cycle:
//   - Up: count==MAX_COUNT -> 0, otherwise count+1.
//   - Down: count==0 -> MAX_COUNT, otherwise count-1.
//   Load press, accepted in either state; state is unchanged:
//   - count <= (load_val > MAX_COUNT) ? MAX_COUNT : load_val (saturate, never wrap).
//   - The prescaler is cleared to 0.
//   - Load has priority over a step in the same cycle; that step is discarded.
//   - Load and run press in the same cycle: both apply (load, toggle state, prescaler=0).
//   tick:
//   - Asserted for exactly 1 cycle after any load or step, even when the value is unchanged.
//   - Never asserted while idle in STOP.
//   Prescaler:
//   - Width is $clog2(PRESCALE), minimum 1 bit.
//   - PRESCALE=1 steps every cycle in RUN.
//   A dir change mid-run takes effect at the next step only; there is no partial step.
//   count never exceeds MAX_COUNT under any input sequence.
//   Reset mid-run: the next cycle is STOP with count=0, and button presses in flight are lost.
// TESTING  (bench uses PRESCALE=4, MAX_COUNT=999)
//   1 Reset: hold rst 2 cycles with buttons released -> count=0, running=0, tick=0 and no tick for 20 cycles.
//   2 Load: load_val=437, pulse load_n low 5 cycles -> count=437 exactly once, tick 1 cycle, running stays 0.
//     Then load_val=1020 with a press -> count=999 (saturate).
//   3 Run up: count=997, dir=1, run press -> steps every 4 cycles: 998, 999, 0, 1; one tick per step.
//     Second run press -> count frozen, running=0.
//   4 Run down wrap: count=1, dir=0, RUN -> 0, 999, 998.
//     Flip dir to 1 mid-interval -> next step gives 999.
//   5 Collision: in RUN, align a load press (load_val=12) with the prescaler wrap cycle -> count=12, no step that cycle.
//     The next step occurs 4 cycles later (13).
//   6 Reset mid-run with load_n held low -> count=0, STOP, and no load occurs after rst releases until load_n is released and pressed again.

Source files
------------

// File: rtl/sw_counter_ctrl_if.sv
// Button/switch inputs and display-count outputs of the switch counter controller.
// The master drives the front-panel inputs; the slave is the counter.
interface sw_counter_ctrl_if;
  logic [9:0] load_val;
  logic       load_n;
  logic       run_n;
  logic       dir;
  logic [9:0] count;
  logic       running;
  logic       tick;

  modport master (
    output load_val, load_n, run_n, dir,
    input  count, running, tick
  );

  modport slave (
    input  load_val, load_n, run_n, dir,
    output count, running, tick
  );
endinterface

// File: rtl/sw_counter_ctrl.sv
// Loadable up/down counter with a prescaled run mode.
// Its count feeds the binary-to-BCD display path.
module sw_counter_ctrl #(
  parameter int PRESCALE  = 50_000_000,
  parameter int MAX_COUNT = 999
) (
  input logic               clk,
  input logic               rst,
  sw_counter_ctrl_if.slave  bus
);

  localparam int             PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]  PS_LAST = PW'(PRESCALE - 1);
  localparam logic [9:0]     CMAX    = 10'(MAX_COUNT);

  typedef enum logic {ST_STOP = 1'b0, ST_RUN = 1'b1} state_t;

  function automatic logic [9:0] sat_load(input logic [9:0] v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  function automatic logic [9:0] step_count(input logic [9:0] c, input logic up);
    if (up) return (c >= CMAX) ? 10'd0 : c + 10'd1;
    else    return (c == 10'd0) ? CMAX : c - 10'd1;
  endfunction

  state_t        state, state_nxt;
  logic          load_p0, load_p1, load_p2;
  logic          run_p0, run_p1, run_p2;
  logic          dir_p0, dir_p1;
  logic [1:0]    settle;
  logic          load_arm, run_arm;
  logic          load_press, run_press;
  logic          running_c, step;
  logic [PW-1:0] presc;
  logic [9:0]    count_r;
  logic          tick_r;

  // Stage p0/p1: two-flop synchronizers; p2: press-detection history.
  // A button must be seen released after reset before it can arm, so a
  // button held through reset never produces a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_p0  <= 1'b1;
      load_p1  <= 1'b1;
      load_p2  <= 1'b1;
      run_p0   <= 1'b1;
      run_p1   <= 1'b1;
      run_p2   <= 1'b1;
      dir_p0   <= 1'b1;
      dir_p1   <= 1'b1;
      settle   <= 2'b00;
      load_arm <= 1'b0;
      run_arm  <= 1'b0;
    end else begin
      load_p0  <= bus.load_n;
      load_p1  <= load_p0;
      load_p2  <= load_p1;
      run_p0   <= bus.run_n;
      run_p1   <= run_p0;
      run_p2   <= run_p1;
      dir_p0   <= bus.dir;
      dir_p1   <= dir_p0;
      settle   <= {settle[0], 1'b1};
      load_arm <= load_arm | (settle[1] & load_p1);
      run_arm  <= run_arm  | (settle[1] & run_p1);
    end
  end

  assign load_press = load_arm & load_p2 & ~load_p1;
  assign run_press  = run_arm  & run_p2  & ~run_p1;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_STOP;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (run_press) state_nxt = (state == ST_RUN) ? ST_STOP : ST_RUN;
  end

  always_comb begin
    running_c = (state == ST_RUN);
    step      = running_c && (presc == PS_LAST);
  end

  // Count update: a load wins over a coincident step and restarts the interval.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= 10'd0;
      presc   <= '0;
      tick_r  <= 1'b0;
    end else begin
      tick_r <= load_press | step;
      if (load_press)  count_r <= sat_load(bus.load_val);
      else if (step)   count_r <= step_count(count_r, dir_p1);
      if (load_press || run_press || step || !running_c) presc <= '0;
      else                                               presc <= presc + PW'(1);
    end
  end

  assign bus.count   = count_r;
  assign bus.running = running_c;
  assign bus.tick    = tick_r;

endmodule
